stage_ex: RTL and testbench
===========================

# stage_ex

Execute stage of the 8-bit, 8-register pipelined core. Sits between the ID/EX pipeline register and `stage_MEM`. It resolves operand forwarding, performs single-cycle ALU ops and an iterative 8-cycle multiply, and drives the EX/MEM pipeline register consumed by `stage_MEM`. During a multiply it stalls the upstream stages and inserts bubbles downstream.

## Interface
Parameters:
- `MUL_CYCLES`, default 8: number of busy iterations for MUL/MULH. Fixed to the operand width.

Ports:
- `clk` input 1: single clock. All state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `flush` input 1: synchronous. Kills the current EX instruction.
- `valid_EX` input 1: the ID/EX slot holds a real instruction.
- `alu_op_EX` input 4: operation code (see Operation).
- `alu_src_EX` input 1: selects the B operand. 1 = `imm_EX`, 0 = forwarded rs2.
- `rs1_data_EX`, `rs2_data_EX`, `imm_EX` input 8 each: operands from ID.
- `forward_A`, `forward_B` input 2 each: forwarding select. 00 = ID data, 01 = `result_WB`, 10 = `alu_result_MEM`, 11 = ID data.
- `result_WB` input 8: writeback-stage result, used for forwarding.
- `MemRead_EX`, `MemWrite_EX`, `ResultSrc_EX`, `RegWrite_EX` input 1 each: control bits.
- `rd_EX` input 3: destination register.
- `alu_result_MEM` output 8: registered ALU result. Also used as a forwarding source.
- `write_data_MEM` output 8: registered forwarded rs2 value, for stores.
- `MemRead_MEM`, `MemWrite_MEM`, `ResultSrc_MEM`, `RegWrite_MEM` output 1 each: registered control bits.
- `rd_MEM` output 3: registered destination register.
- `stall_EX` output 1: combinational. High means PC, IF/ID and ID/EX must hold.
- `mul_busy` output 1: FSM is in the BUSY state (debug/visibility).

## Operation
- Operand A is `rs1_data_EX` after forwarding on `forward_A`.
- Forwarded rs2 (`fwdB`) is `rs2_data_EX` after forwarding on `forward_B`. Operand B is `imm_EX` if `alu_src_EX`, else `fwdB`.
- Op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL and 6 SRL: shift amount is B[2:0].
  - 7 SLT: signed compare, result 8'h01 or 8'h00.
  - 8 MUL: low byte of the unsigned 16-bit product.
  - 9 MULH: high byte of the unsigned 16-bit product.
  - 10–15: result 8'h00; control bits pass through unchanged.
- All arithmetic is 8-bit and wraps modulo 256. No flags.
- FSM states:
  - IDLE → BUSY when `valid_EX`, op is 8 or 9, and neither `flush` nor `reset` is high. On that edge, latch operand A, operand B, op, rd and the control bits; clear the 16-bit accumulator and `cnt`.
  - BUSY: one shift-add per cycle; `cnt` increments 0..7.
  - BUSY with `cnt`==7 → IDLE. On that edge, write the final product byte and the latched control bits into EX/MEM.
  - BUSY → IDLE on `flush`: abort, no writeback.
- `stall_EX` = (IDLE & `valid_EX` & op∈{8,9}) | (BUSY & `cnt`≠7).
- While `stall_EX` is high, EX/MEM is loaded with a bubble: all four control bits 0, `rd_MEM` 0, data 0.
- Operands are captured at issue. Forwarding inputs are ignored during BUSY, because the MEM and WB stages drain during the stall.
- Non-multiply, `valid_EX`=1: EX/MEM is loaded with the ALU result, `fwdB` and the control bits on the next edge.
- `valid_EX`=0 or `flush`: EX/MEM is loaded with a bubble.

## Timing
- Reset: every registered output is 0, FSM is IDLE, `cnt`=0. `stall_EX` and `mul_busy` are therefore 0.
- Single-cycle ops: latency 1. The result is visible on `alu_result_MEM` the cycle after the instruction occupies EX.
- MUL/MULH: the issue cycle plus 8 BUSY cycles. `stall_EX` is high for 8 consecutive cycles (issue and `cnt` 0..6). The result is visible 9 cycles after issue. 8 bubbles reach MEM before the result.
- Back-to-back MULs: the second one issues on the cycle after the first completes.
- `reset` and `flush` together: reset wins. Reset in BUSY: IDLE on the next edge, no writeback.
- `flush` on the issue cycle: no BUSY entry, bubble written.
- `flush` at `cnt`==7: abort; the flush wins over completion.

## Structure
- Shared package `cpu_pkg`:
  - ALU op localparams `ALU_ADD`..`ALU_MULH`.
  - Forward-select encodings `FWD_ID`, `FWD_WB`, `FWD_MEM`.
  - FSM state encoding `EX_IDLE`, `EX_BUSY`.
- One sub-module, `mul_seq8`: the iterative shift-add multiplier with start/abort/done. `stage_ex` holds the forwarding, ALU, stall logic and the EX/MEM register.

## Test plan
- ADD with A=8'hF0, B=8'h20, no forwarding → next cycle `alu_result_MEM`=8'h10, control bits copied, `stall_EX`=0.
- SUB with `forward_A`=10, `alu_result_MEM`=8'h05, rs1 stale=8'hAA, B=8'h07 → result 8'hFE. Separately, SLT with A=8'hFF, B=8'h01 → result 8'h01.
- MUL with A=8'h0F, B=8'h11 → `stall_EX` high exactly 8 cycles, 8 bubbles with `RegWrite_MEM`=0, then `alu_result_MEM`=8'hFF at issue+9. The same operands with MULH → 8'h00. A=8'hFF, B=8'hFF with MULH → 8'hFE.
- MUL issued; on cycle 3 the forward sources change and `rs1_data_EX` toggles → product unchanged, computed from the operands latched at issue.
- `flush` at `cnt`==4 during MUL → IDLE next cycle, no result written, `stall_EX` drops. A following ADD completes normally.
- `reset` asserted mid-MUL, together with `flush` → all outputs 0 and IDLE after one edge. A store with `forward_B`=01, `result_WB`=8'h3C → `write_data_MEM`=8'h3C, `MemWrite_MEM`=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit pipelined core: ALU op codes, forwarding
// selects and the execute-stage FSM encoding.
package cpu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_MUL  = 4'd8;
  localparam logic [3:0] ALU_MULH = 4'd9;

  localparam logic [1:0] FWD_ID  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    EX_IDLE = 1'b0,
    EX_BUSY = 1'b1
  } ex_state_e;

  // Encoding 2'b11 falls back to the ID operand.
  function automatic logic [7:0] fwd_select(input logic [1:0] sel, input logic [7:0] id_val,
                                            input logic [7:0] wb_val, input logic [7:0] mem_val);
    logic [7:0] res;
    res = id_val;
    if (sel == FWD_WB) res = wb_val;
    else if (sel == FWD_MEM) res = mem_val;
    return res;
  endfunction

endpackage

// File: rtl/mul_seq8.sv
// Iterative shift-add multiplier: one partial product per cycle, with the
// final sum presented combinationally during the last iteration.
module mul_seq8
  import cpu_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        last,
  output logic [15:0] product
);

  localparam int unsigned CntW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MUL_CYCLES - 1);

  ex_state_e       state_q;
  logic [CntW-1:0] cnt_q;
  logic [15:0]     mcand_q;
  logic [15:0]     acc_q;
  logic [7:0]      mplier_q;
  logic [15:0]     acc_step;

  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : 16'h0000);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= EX_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
    end else begin
      unique case (state_q)
        EX_IDLE: begin
          if (start) begin
            state_q  <= EX_BUSY;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= {8'h00, a};
            mplier_q <= b;
          end
        end
        EX_BUSY: begin
          if (abort || (cnt_q == CntLast)) begin
            state_q <= EX_IDLE;
            cnt_q   <= '0;
          end else begin
            acc_q    <= acc_step;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CntW'(1);
          end
        end
      endcase
    end
  end

  assign busy    = (state_q == EX_BUSY);
  assign last    = busy && (cnt_q == CntLast);
  // Includes the final partial product, valid while last is high.
  assign product = acc_step;

endmodule

// File: rtl/stage_ex.sv
// Execute stage: operand forwarding, single-cycle ALU, multicycle multiply
// with upstream stall, and the EX/MEM pipeline register.
module stage_ex
  import cpu_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       valid_EX,
  input  logic [3:0] alu_op_EX,
  input  logic       alu_src_EX,
  input  logic [7:0] rs1_data_EX,
  input  logic [7:0] rs2_data_EX,
  input  logic [7:0] imm_EX,
  input  logic [1:0] forward_A,
  input  logic [1:0] forward_B,
  input  logic [7:0] result_WB,
  input  logic       MemRead_EX,
  input  logic       MemWrite_EX,
  input  logic       ResultSrc_EX,
  input  logic       RegWrite_EX,
  input  logic [2:0] rd_EX,
  output logic [7:0] alu_result_MEM,
  output logic [7:0] write_data_MEM,
  output logic       MemRead_MEM,
  output logic       MemWrite_MEM,
  output logic       ResultSrc_MEM,
  output logic       RegWrite_MEM,
  output logic [2:0] rd_MEM,
  output logic       stall_EX,
  output logic       mul_busy
);

  logic [7:0]  op_a;
  logic [7:0]  fwd_b;
  logic [7:0]  op_b;
  logic [7:0]  alu_res;
  logic        is_mul;
  logic        mul_start;
  logic        mul_last;
  logic [15:0] product;
  logic [7:0]  mul_byte;
  logic [3:0]  ctl_ex;

  logic [3:0]  op_q;
  logic [2:0]  rd_q;
  logic [3:0]  ctl_q;

  assign op_a   = fwd_select(forward_A, rs1_data_EX, result_WB, alu_result_MEM);
  assign fwd_b  = fwd_select(forward_B, rs2_data_EX, result_WB, alu_result_MEM);
  assign op_b   = alu_src_EX ? imm_EX : fwd_b;
  assign ctl_ex = {MemRead_EX, MemWrite_EX, ResultSrc_EX, RegWrite_EX};

  always_comb begin
    alu_res = 8'h00;
    case (alu_op_EX)
      ALU_ADD: alu_res = op_a + op_b;
      ALU_SUB: alu_res = op_a - op_b;
      ALU_AND: alu_res = op_a & op_b;
      ALU_OR:  alu_res = op_a | op_b;
      ALU_XOR: alu_res = op_a ^ op_b;
      ALU_SLL: alu_res = op_a << op_b[2:0];
      ALU_SRL: alu_res = op_a >> op_b[2:0];
      ALU_SLT: alu_res = ($signed(op_a) < $signed(op_b)) ? 8'h01 : 8'h00;
      default: alu_res = 8'h00;
    endcase
  end

  assign is_mul    = (alu_op_EX == ALU_MUL) || (alu_op_EX == ALU_MULH);
  assign mul_start = !mul_busy && valid_EX && is_mul && !flush;
  // The multiply holds the pipeline until its final iteration, when the
  // stalled ID/EX slot is released at the same edge the result retires.
  assign stall_EX  = (!mul_busy && valid_EX && is_mul) || (mul_busy && !mul_last);

  mul_seq8 #(
    .MUL_CYCLES(MUL_CYCLES)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .abort   (flush),
    .a       (op_a),
    .b       (op_b),
    .busy    (mul_busy),
    .last    (mul_last),
    .product (product)
  );

  assign mul_byte = (op_q == ALU_MULH) ? product[15:8] : product[7:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q  <= '0;
      rd_q  <= '0;
      ctl_q <= '0;
    end else if (mul_start) begin
      op_q  <= alu_op_EX;
      rd_q  <= rd_EX;
      ctl_q <= ctl_ex;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush || (stall_EX && !mul_last)) begin
      alu_result_MEM <= '0;
      write_data_MEM <= '0;
      {MemRead_MEM, MemWrite_MEM, ResultSrc_MEM, RegWrite_MEM} <= '0;
      rd_MEM         <= '0;
    end else if (mul_last) begin
      alu_result_MEM <= mul_byte;
      write_data_MEM <= '0;
      {MemRead_MEM, MemWrite_MEM, ResultSrc_MEM, RegWrite_MEM} <= ctl_q;
      rd_MEM         <= rd_q;
    end else if (valid_EX && !is_mul) begin
      alu_result_MEM <= alu_res;
      write_data_MEM <= fwd_b;
      {MemRead_MEM, MemWrite_MEM, ResultSrc_MEM, RegWrite_MEM} <= ctl_ex;
      rd_MEM         <= rd_EX;
    end else begin
      alu_result_MEM <= '0;
      write_data_MEM <= '0;
      {MemRead_MEM, MemWrite_MEM, ResultSrc_MEM, RegWrite_MEM} <= '0;
      rd_MEM         <= '0;
    end
  end

endmodule

// File: tb/tb_stage_ex.sv
// Scoreboard bench for stage_ex: expected EX/MEM contents are queued per
// driven cycle and compared on the following falling edge.
module tb_stage_ex;

  logic       clk = 1'b0;
  logic       reset, flush, valid_EX, alu_src_EX;
  logic [3:0] alu_op_EX;
  logic [7:0] rs1_data_EX, rs2_data_EX, imm_EX, result_WB;
  logic [1:0] forward_A, forward_B;
  logic       MemRead_EX, MemWrite_EX, ResultSrc_EX, RegWrite_EX;
  logic [2:0] rd_EX;
  logic [7:0] alu_result_MEM, write_data_MEM;
  logic       MemRead_MEM, MemWrite_MEM, ResultSrc_MEM, RegWrite_MEM;
  logic [2:0] rd_MEM;
  logic       stall_EX, mul_busy;

  typedef struct packed {
    logic [7:0] res;
    logic [7:0] wd;
    logic [3:0] ctl;
    logic [2:0] rd;
    logic       busy;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  stage_ex dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .valid_EX      (valid_EX),
    .alu_op_EX     (alu_op_EX),
    .alu_src_EX    (alu_src_EX),
    .rs1_data_EX   (rs1_data_EX),
    .rs2_data_EX   (rs2_data_EX),
    .imm_EX        (imm_EX),
    .forward_A     (forward_A),
    .forward_B     (forward_B),
    .result_WB     (result_WB),
    .MemRead_EX    (MemRead_EX),
    .MemWrite_EX   (MemWrite_EX),
    .ResultSrc_EX  (ResultSrc_EX),
    .RegWrite_EX   (RegWrite_EX),
    .rd_EX         (rd_EX),
    .alu_result_MEM(alu_result_MEM),
    .write_data_MEM(write_data_MEM),
    .MemRead_MEM   (MemRead_MEM),
    .MemWrite_MEM  (MemWrite_MEM),
    .ResultSrc_MEM (ResultSrc_MEM),
    .RegWrite_MEM  (RegWrite_MEM),
    .rd_MEM        (rd_MEM),
    .stall_EX      (stall_EX),
    .mul_busy      (mul_busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check_eq("alu_result_MEM", 32'(alu_result_MEM), 32'(e.res));
      check_eq("write_data_MEM", 32'(write_data_MEM), 32'(e.wd));
      check_eq("ctl_MEM", 32'({MemRead_MEM, MemWrite_MEM, ResultSrc_MEM, RegWrite_MEM}),
               32'(e.ctl));
      check_eq("rd_MEM", 32'(rd_MEM), 32'(e.rd));
      check_eq("mul_busy", 32'(mul_busy), 32'(e.busy));
    end
  end

  // Inputs are already applied; check the combinational stall, queue what
  // EX/MEM must hold after the coming edge, then return just past the
  // falling edge where that entry is compared.
  task automatic tick(input exp_t e, input logic exp_stall, input string tag);
    #1;
    check_eq(tag, 32'(stall_EX), 32'(exp_stall));
    sb.push_back(e);
    @(negedge clk);
    #2;
  endtask

  function automatic exp_t mk(input logic [7:0] res, input logic [7:0] wd, input logic [3:0] ctl,
                              input logic [2:0] rd, input logic busy);
    exp_t e;
    e.res = res; e.wd = wd; e.ctl = ctl; e.rd = rd; e.busy = busy;
    return e;
  endfunction

  task automatic set_instr(input logic [3:0] op, input logic src, input logic [7:0] rs1,
                           input logic [7:0] rs2, input logic [7:0] imm, input logic [3:0] ctl,
                           input logic [2:0] rd);
    valid_EX = 1'b1; alu_op_EX = op; alu_src_EX = src;
    rs1_data_EX = rs1; rs2_data_EX = rs2; imm_EX = imm;
    {MemRead_EX, MemWrite_EX, ResultSrc_EX, RegWrite_EX} = ctl;
    rd_EX = rd;
  endtask

  // kill_at: cycle index (0 = issue) that asserts flush (and reset if
  // kill_reset); perturb_at: cycle where operand/forward inputs get scrambled.
  task automatic do_mul(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_res, input logic [3:0] ctl, input logic [2:0] rd,
                        input int kill_at, input bit kill_reset, input int perturb_at);
    set_instr(op, 1'b0, a, b, 8'h00, ctl, rd);
    forward_A = 2'b00; forward_B = 2'b00;
    for (int k = 0; k <= 8; k++) begin
      if (k == perturb_at) begin
        rs1_data_EX = ~a; rs2_data_EX = 8'h3B;
        forward_A = 2'b01; forward_B = 2'b10; result_WB = 8'h5A;
      end
      if (k == kill_at) begin
        flush = 1'b1;
        reset = kill_reset;
        tick(mk(8'h00, 8'h00, 4'h0, 3'd0, 1'b0), (k < 8), "stall_kill");
        flush = 1'b0;
        reset = 1'b0;
        forward_A = 2'b00; forward_B = 2'b00;
        return;
      end
      if (k < 8) tick(mk(8'h00, 8'h00, 4'h0, 3'd0, 1'b1), 1'b1, "stall_mul");
      else tick(mk(exp_res, 8'h00, ctl, rd, 1'b0), 1'b0, "stall_mul_done");
    end
    forward_A = 2'b00; forward_B = 2'b00;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; valid_EX = 1'b0; alu_src_EX = 1'b0; alu_op_EX = 4'h0;
    rs1_data_EX = 8'h00; rs2_data_EX = 8'h00; imm_EX = 8'h00; result_WB = 8'h00;
    forward_A = 2'b00; forward_B = 2'b00; rd_EX = 3'd0;
    {MemRead_EX, MemWrite_EX, ResultSrc_EX, RegWrite_EX} = 4'h0;
    @(negedge clk); #2;

    // Reset with garbage inputs present: everything must read zero.
    set_instr(4'd0, 1'b1, 8'h12, 8'h34, 8'h56, 4'hF, 3'd7);
    tick(mk(8'h00, 8'h00, 4'h0, 3'd0, 1'b0), 1'b0, "stall_reset");
    reset = 1'b0;

    set_instr(4'd0, 1'b1, 8'hF0, 8'h33, 8'h20, 4'b0001, 3'd3);        // ADD wraps
    tick(mk(8'h10, 8'h33, 4'b0001, 3'd3, 1'b0), 1'b0, "stall_add");
    set_instr(4'd0, 1'b1, 8'h02, 8'h00, 8'h03, 4'b0001, 3'd1);        // ADD -> 05
    tick(mk(8'h05, 8'h00, 4'b0001, 3'd1, 1'b0), 1'b0, "stall_add2");
    set_instr(4'd1, 1'b1, 8'hAA, 8'h00, 8'h07, 4'b0001, 3'd2);        // SUB fwd MEM
    forward_A = 2'b10;
    tick(mk(8'hFE, 8'h00, 4'b0001, 3'd2, 1'b0), 1'b0, "stall_sub");
    forward_A = 2'b00;
    set_instr(4'd7, 1'b0, 8'hFF, 8'h01, 8'h00, 4'b0001, 3'd4);        // SLT signed
    tick(mk(8'h01, 8'h01, 4'b0001, 3'd4, 1'b0), 1'b0, "stall_slt");
    set_instr(4'd5, 1'b1, 8'h81, 8'h9C, 8'h0B, 4'b0011, 3'd5);        // SLL by 3
    tick(mk(8'h08, 8'h9C, 4'b0011, 3'd5, 1'b0), 1'b0, "stall_sll");
    set_instr(4'd6, 1'b1, 8'h81, 8'h00, 8'h0B, 4'b0001, 3'd5);        // SRL by 3
    tick(mk(8'h10, 8'h00, 4'b0001, 3'd5, 1'b0), 1'b0, "stall_srl");
    set_instr(4'd4, 1'b0, 8'hA5, 8'h0F, 8'h00, 4'b0001, 3'd6);        // XOR
    tick(mk(8'hAA, 8'h0F, 4'b0001, 3'd6, 1'b0), 1'b0, "stall_xor");
    set_instr(4'd12, 1'b0, 8'hA5, 8'h0F, 8'h00, 4'b1010, 3'd7);       // undefined op
    tick(mk(8'h00, 8'h0F, 4'b1010, 3'd7, 1'b0), 1'b0, "stall_op12");
    set_instr(4'd0, 1'b0, 8'h11, 8'h22, 8'h00, 4'b1111, 3'd7);
    valid_EX = 1'b0;                                                   // invalid slot
    tick(mk(8'h00, 8'h00, 4'h0, 3'd0, 1'b0), 1'b0, "stall_invalid");

    do_mul(4'd8, 8'h0F, 8'h11, 8'hFF, 4'b0001, 3'd5, -1, 1'b0, -1);  // MUL
    do_mul(4'd9, 8'h0F, 8'h11, 8'h00, 4'b0001, 3'd6, -1, 1'b0, -1);  // back-to-back MULH
    do_mul(4'd9, 8'hFF, 8'hFF, 8'hFE, 4'b0101, 3'd2, -1, 1'b0, 3);   // inputs disturbed
    do_mul(4'd8, 8'h0F, 8'h11, 8'hFF, 4'b0001, 3'd5, 5, 1'b0, -1);   // flush at cnt 4
    set_instr(4'd0, 1'b1, 8'h21, 8'h00, 8'h12, 4'b0001, 3'd1);
    tick(mk(8'h33, 8'h00, 4'b0001, 3'd1, 1'b0), 1'b0, "stall_after_flush");
    do_mul(4'd8, 8'h0F, 8'h11, 8'hFF, 4'b0001, 3'd5, 0, 1'b0, -1);   // flush at issue
    do_mul(4'd8, 8'h0F, 8'h11, 8'hFF, 4'b0001, 3'd5, 8, 1'b0, -1);   // flush at cnt 7
    do_mul(4'd9, 8'hFF, 8'hFF, 8'hFE, 4'b0001, 3'd5, 4, 1'b1, -1);   // reset+flush mid-MUL

    set_instr(4'd0, 1'b1, 8'h10, 8'h99, 8'h04, 4'b0100, 3'd0);        // store, fwd WB
    forward_B = 2'b01; result_WB = 8'h3C;
    tick(mk(8'h14, 8'h3C, 4'b0100, 3'd0, 1'b0), 1'b0, "stall_store");
    forward_B = 2'b00;
    valid_EX = 1'b0;
    tick(mk(8'h00, 8'h00, 4'h0, 3'd0, 1'b0), 1'b0, "stall_idle");

    check_eq("scoreboard_drain", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
